fp_div: RTL and testbench
=========================

// Module: fp_div
// PURPOSE
// Iterative IEEE-754 single-precision divider (quo = flp_a / flp_b), the inverse companion of the combinational multiplier.
// Multicycle FP unit for the processor datapath: start/busy/done handshake, fixed latency, restoring radix-2 divide,
// round-to-nearest-even. No NaN/Inf/subnormal support: exponent field 0 means zero; exceptional results flagged and saturated.
// PARAMETERS
// EXP_W   8   exponent field width (only default verified)
// FRAC_W  23  stored fraction width (only default verified); ITER = FRAC_W+3 = 26 quotient bits
// PORTS
// clk     in   1   rising-edge clock
// reset_n in   1   asynchronous active-low reset
// start   in   1   request; accepted only when busy=0
// flp_a   in   32  dividend {sign,exp,frac}, sampled on accepting edge
// flp_b   in   32  divisor, sampled on accepting edge
// quo     out  32  registered result; holds until next done
// busy    out  1   high from accepting edge until done edge
// done    out  1   one-cycle pulse, quo/flags valid
// ovf     out  1   result exponent >= 255 (saturated)
// unf     out  1   result exponent <= 0 (flushed to zero)
// dbz     out  1   divisor zero (exp field 0)
// BEHAVIOUR
// - Reset (any time, incl. mid-divide): state=IDLE, quo=0, busy=0, done=0, ovf=unf=dbz=0, iteration counter=0.
// - FSM IDLE -> DIV -> NORM -> IDLE. IDLE: start=1 latches operands, sign=sa^sb, eraw=ea-eb (10-bit signed), rem={1,fa}, div={1,fb}, cnt=0, busy=1.
// - DIV: per cycle: if rem>=div {q=q<<1|1; rem=(rem-div)<<1} else {q=q<<1; rem=rem<<1}; cnt++; after 26th iteration -> NORM. rem width 25 bits.
// - NORM (1 cycle): if q[25]: frac=q[24:2], g=q[1], s=q[0]|(rem!=0), e=eraw+127; else frac=q[23:1], g=q[0], s=(rem!=0), e=eraw+126.
//   Round up iff g&(s|frac[0]); carry out of frac -> frac=0, e=e+1. Register quo/flags, done=1, busy=0, -> IDLE.
// - Priority in NORM: dbz (fb exp=0, incl. 0/0): quo={sign,8'hFE,23'h7FFFFF}, dbz=1; else a zero: quo={sign,31'b0};
//   else e>=255: quo={sign,8'hFE,23'h7FFFFF}, ovf=1; else e<=0: quo={sign,31'b0}, unf=1; else {sign,e[7:0],frac}.
// - Flags are cleared on every accepted start; hold with quo until next done.
// - Latency: start sampled at edge k -> done=1 after edge k+27 (27 cycles), independent of operand values.
// - start while busy=1: ignored, no effect on operands or timing. start in the cycle done=1 (state IDLE): accepted; done falls next cycle.
// - Operands need only be stable at the accepting edge; later changes ignored.
// TESTING
// 1. 0x40C00000 / 0x40000000 (6/2) -> quo=0x40400000, flags 0, done exactly 27 cycles after start, busy high for those 27.
// 2. 0x3F800000 / 0x40400000 (1/3) -> quo=0x3EAAAAAB (RNE round-up); 0x3F800000/0x3F800000 -> 0x3F800000.
// 3. 0xBF800000 / 0x00000000 -> dbz=1, quo=0xFF7FFFFF; 0x00000000/0x00000000 -> dbz=1, quo=0x7F7FFFFF.
// 4. 0x7F000000 / 0x3F000000 -> ovf=1, quo=0x7F7FFFFF; 0x00800000 / 0x40000000 -> unf=1, quo=0x00000000; 0x80000000/0x40A00000 -> 0x80000000, no flags.
// 5. Pulse start with new operands at cycles 5 and 12 of a busy divide -> ignored; result equals first operands; back-to-back start on done cycle accepted.
// 6. reset_n low at cycle 10 of a divide -> busy=done=0, quo=0 immediately; after release, 6/2 completes correctly in 27 cycles.

Source files
------------

// File: rtl/fp_div_if.sv
// Handshake/operand bundle between a requester and the fp_div divider.
// Latency: none (wiring only).
// Backpressure: requester must hold off start while busy; starts seen during busy are dropped.
//
// Ports (master = requester, slave = divider):
//   start        request strobe, taken only while busy=0
//   flp_a/flp_b  dividend / divisor {sign,exp,frac}
//   quo          registered quotient, held until the next done
//   busy/done    busy spans the divide, done pulses one cycle with the result
//   ovf/unf/dbz  overflow-saturated / underflow-flushed / divide-by-zero flags
interface fp_div_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] flp_a;
  logic [W-1:0] flp_b;
  logic [W-1:0] quo;
  logic         busy;
  logic         done;
  logic         ovf;
  logic         unf;
  logic         dbz;

  modport master (output start, flp_a, flp_b,
                  input  quo, busy, done, ovf, unf, dbz);
  modport slave  (input  start, flp_a, flp_b,
                  output quo, busy, done, ovf, unf, dbz);
endinterface

// File: rtl/fp_div.sv
// Iterative single-precision divider (quo = flp_a / flp_b), restoring radix-2, round-to-nearest-even.
// Latency: fixed 27 cycles from the accepting edge to done, independent of operands.
// Backpressure: busy=1 for the whole divide; start while busy is ignored, start on the done cycle is taken.
//
// Ports: clk, reset_n (async active-low) plain; bus (fp_div_if.slave) carries
//   start/flp_a/flp_b in and quo/busy/done/ovf/unf/dbz out.
// Exponent field 0 is treated as zero; no NaN/Inf/subnormal handling, out-of-range results saturate or flush.
module fp_div #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic   clk,
  input  logic   reset_n,
  fp_div_if.slave bus
);
  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int ITER  = FRAC_W + 3;          // quotient bits: hidden + frac + guard + one extra
  localparam int MW    = FRAC_W + 1;          // mantissa width with hidden bit
  localparam int CW    = $clog2(ITER);
  localparam int EW    = EXP_W + 2;           // signed exponent working width
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX  = (1 << EXP_W) - 1;

  localparam logic signed [EW-1:0] C_BIAS    = EW'(BIAS);
  localparam logic signed [EW-1:0] C_BIAS_M1 = EW'(BIAS - 1);
  localparam logic signed [EW-1:0] C_EMAX    = EW'(EMAX);
  localparam logic [CW-1:0]        C_LAST    = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_sign;
  logic signed [EW-1:0]  r_eraw;
  logic                  r_a_zero, r_b_zero;
  logic [MW:0]           r_rem;               // one bit wider than div: rem < 2*div always
  logic [MW-1:0]         r_div;
  logic [ITER-1:0]       r_q;
  logic [CW-1:0]         r_cnt;
  logic [W-1:0]          r_quo;
  logic                  r_done, r_ovf, r_unf, r_dbz;

  logic [EXP_W-1:0]      w_ea, w_eb;
  logic                  w_ge;
  logic [MW:0]           w_rem_sub, w_rem_nxt;
  logic [FRAC_W-1:0]     w_frac;
  logic                  w_g, w_s, w_rnd;
  logic [FRAC_W:0]       w_frac_sum;
  logic signed [EW-1:0]  w_exp, w_exp_r;
  logic [W-1:0]          w_quo_nxt;
  logic                  w_ovf_nxt, w_unf_nxt, w_dbz_nxt;
  logic [W-1:0]          w_sat;

  assign w_ea = bus.flp_a[W-2:FRAC_W];
  assign w_eb = bus.flp_b[W-2:FRAC_W];

  // One restoring step; a subtracted remainder is always < div, so it fits before the shift.
  assign w_ge      = (r_rem >= {1'b0, r_div});
  assign w_rem_sub = r_rem - {1'b0, r_div};
  assign w_rem_nxt = w_ge ? {w_rem_sub[MW-1:0], 1'b0} : {r_rem[MW-1:0], 1'b0};

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_DIV;
      S_DIV:   if (r_cnt == C_LAST) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Normalise, round and classify the finished quotient.
  always_comb begin
    w_sat = {r_sign, EXP_W'(EMAX - 1), {FRAC_W{1'b1}}};
    if (r_q[ITER-1]) begin
      // quotient in [1,2)
      w_frac = r_q[ITER-2:2];
      w_g    = r_q[1];
      w_s    = r_q[0] | (|r_rem);
      w_exp  = r_eraw + C_BIAS;
    end else begin
      // quotient in [0.5,1): shift left one, exponent one lower
      w_frac = r_q[ITER-3:1];
      w_g    = r_q[0];
      w_s    = |r_rem;
      w_exp  = r_eraw + C_BIAS_M1;
    end
    w_rnd      = w_g & (w_s | w_frac[0]);
    w_frac_sum = {1'b0, w_frac} + {{FRAC_W{1'b0}}, w_rnd};
    // carry out of the fraction leaves frac=0 and bumps the exponent
    w_exp_r    = w_exp + $signed({{(EW-1){1'b0}}, w_frac_sum[FRAC_W]});

    w_quo_nxt = {r_sign, w_exp_r[EXP_W-1:0], w_frac_sum[FRAC_W-1:0]};
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    w_dbz_nxt = 1'b0;
    if (r_b_zero) begin
      w_quo_nxt = w_sat;
      w_dbz_nxt = 1'b1;
    end else if (r_a_zero) begin
      w_quo_nxt = {r_sign, {(W-1){1'b0}}};
    end else if (!w_exp_r[EW-1] && (w_exp_r >= C_EMAX)) begin
      w_quo_nxt = w_sat;
      w_ovf_nxt = 1'b1;
    end else if (w_exp_r[EW-1] || (w_exp_r == '0)) begin
      w_quo_nxt = {r_sign, {(W-1){1'b0}}};
      w_unf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sign   <= 1'b0;
      r_eraw   <= '0;
      r_a_zero <= 1'b0;
      r_b_zero <= 1'b0;
      r_rem    <= '0;
      r_div    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sign   <= bus.flp_a[W-1] ^ bus.flp_b[W-1];
            r_eraw   <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb});
            r_a_zero <= (w_ea == '0);
            r_b_zero <= (w_eb == '0);
            r_rem    <= {2'b01, bus.flp_a[FRAC_W-1:0]};
            r_div    <= {1'b1, bus.flp_b[FRAC_W-1:0]};
            r_q      <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_dbz    <= 1'b0;
          end
        end
        S_DIV: begin
          r_q   <= {r_q[ITER-2:0], w_ge};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_NORM: begin
          r_quo  <= w_quo_nxt;
          r_ovf  <= w_ovf_nxt;
          r_unf  <= w_unf_nxt;
          r_dbz  <= w_dbz_nxt;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.quo  = r_quo;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;
  assign bus.unf  = r_unf;
  assign bus.dbz  = r_dbz;
endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: directed operand pairs with hand-computed quotients.
// Driver pushes the expected result and completion cycle; a negedge monitor pops on done.
module tb_fp_div;
  logic clk;
  logic reset_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  fp_div_if #(.W(32)) bus ();

  fp_div dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] quo;
    logic [2:0]  flg;   // {ovf,unf,dbz}
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: quo %h with empty scoreboard", bus.quo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_quo"}, bus.quo, e.quo);
        chk({e.name, "_flags"}, {29'd0, bus.ovf, bus.unf, bus.dbz}, {29'd0, e.flg});
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one negedge later, operands scrambled.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                       input logic [2:0] f, input string name, input bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.flp_a = a;
    bus.flp_b = b;
    if (push) begin
      e.quo  = q;
      e.flg  = f;
      e.cyc  = cyc + 28;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.flp_a = $urandom;
    bus.flp_b = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, n);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                     input logic [2:0] f, input string name);
    issue(a, b, q, f, name, 1'b1);
    wait_done(name);
    @(negedge clk);
  endtask

  initial begin
    int nb;
    n_chk     = 0;
    n_fail    = 0;
    cyc       = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.flp_a = '0;
    bus.flp_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_quo", bus.quo, 32'h0);
    chk("rst_ctl", {29'd0, bus.busy, bus.done, bus.ovf | bus.unf | bus.dbz}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 6/2 with explicit busy-width check
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, "six_by_two", 1'b1);
    nb = 0;
    while (bus.busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(nb), 32'd27);
    @(negedge clk);

    run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, "one_third");
    run(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, "one_by_one");
    run(32'h40000000, 32'h3F800000, 32'h40000000, 3'b000, "two_by_one");
    run(32'hC0400000, 32'h3F800000, 32'hC0400000, 3'b000, "neg_three");
    run(32'hBF800000, 32'h00000000, 32'hFF7FFFFF, 3'b001, "neg_by_zero");
    run(32'h00000000, 32'h00000000, 32'h7F7FFFFF, 3'b001, "zero_by_zero");
    run(32'h7F000000, 32'h3F000000, 32'h7F7FFFFF, 3'b100, "overflow");
    run(32'h00800000, 32'h40000000, 32'h00000000, 3'b010, "underflow");
    run(32'h80000000, 32'h40A00000, 32'h80000000, 3'b000, "neg_zero_num");

    // start pulses mid-divide must be dropped
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, "ignore_start", 1'b1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.flp_a = 32'h3F800000; bus.flp_b = 32'h40400000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.start = 1'b1; bus.flp_a = 32'h7F000000; bus.flp_b = 32'h3F000000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_start");
    // back-to-back: start on the done cycle
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, "back_to_back", 1'b1);
    chk("done_falls", {31'd0, bus.done}, 32'h0);
    wait_done("back_to_back");
    @(negedge clk);

    // reset in the middle of a divide
    issue(32'h3F800000, 32'h40400000, 32'h0, 3'b000, "aborted", 1'b0);
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_quo", bus.quo, 32'h0);
    chk("midrst_ctl", {29'd0, bus.busy, bus.done, bus.ovf | bus.unf | bus.dbz}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, "after_reset");

    repeat (35) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
